aes_sha3_host_seq: RTL and testbench

Host-side sequencer that drives the byte-serial port of the AES/SHA3 PBKDF2-HMAC core. It accepts one parallel command (256-bit salt‖key, 128-bit message, mode), serializes it into the core, waits out key derivation, and deserializes the 16-byte cipher and 32-byte MAC the core streams back. It then presents them as one parallel result. It sits between the system bus adapter and the core; the core's `i_*` ports connect to this block's `dut_*` outputs, and vice versa.

---
 rtl/aes_sha3_pkg.sv | 24 ++
 rtl/aes_sha3_host_seq_if.sv | 44 ++++
 rtl/byte_deser.sv | 26 ++
 rtl/aes_sha3_host_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_aes_sha3_host_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sha3_pkg.sv
// Shared types and sizes for the AES/SHA3 host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_sha3_pkg;

  localparam int KEY_BYTES              = 32;
  localparam int MSG_BYTES              = 16;
  localparam int CIPHER_BYTES           = 16;
  localparam int MAC_BYTES              = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_KEY,
    ST_WAIT_BUSY,
    ST_WAIT_MSG,
    ST_SEND_MSG,
    ST_WAIT_OUT,
    ST_RX_CIPHER,
    ST_RX_MAC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/aes_sha3_host_seq_if.sv
// Command/result handshake plus byte-serial core port of the host sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd valid/ready in, res valid/ready out; core side has no backpressure.
interface aes_sha3_host_seq_if;

  // command side
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] cmd_salt_key;
  logic [127:0] cmd_msg;
  logic         cmd_mode;

  // result side
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_cipher;
  logic [255:0] res_mac;
  logic         res_err;

  // byte-serial core side
  logic [7:0]   dut_data;
  logic         dut_start;
  logic         dut_mode;
  logic [7:0]   dut_odata;
  logic         dut_ovalid;
  logic         dut_ien;

  // the sequencer itself
  modport master (
    input  cmd_valid, cmd_salt_key, cmd_msg, cmd_mode, res_ready,
    input  dut_odata, dut_ovalid, dut_ien,
    output cmd_ready, res_valid, res_cipher, res_mac, res_err,
    output dut_data, dut_start, dut_mode
  );

  // everything around it: bus adapter and core
  modport slave (
    output cmd_valid, cmd_salt_key, cmd_msg, cmd_mode, res_ready,
    output dut_odata, dut_ovalid, dut_ien,
    input  cmd_ready, res_valid, res_cipher, res_mac, res_err,
    input  dut_data, dut_start, dut_mode
  );

endinterface

// File: rtl/byte_deser.sv
// Indexed byte-capture register: writes one byte at a chosen lane, clears as a whole.
// Latency: one cycle from write-enable to visible byte.
// Backpressure: none; every enabled write lands.
module byte_deser #(
  parameter  int NBYTES = 16,
  localparam int IW     = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [IW-1:0]         idx,
  input  logic [7:0]            din,
  output logic [NBYTES*8-1:0]   dat
);

  // byte lane idx receives din; clear wipes any partial result
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dat <= '0;
    end else if (we) begin
      dat[{idx, 3'b000} +: 8] <= din;
    end
  end

endmodule

// File: rtl/aes_sha3_host_seq.sv
// Host sequencer for the byte-serial AES/SHA3 PBKDF2-HMAC core (watchdog under AES_SHA3_HOST_TIMEOUT_EN).
// Latency: first key byte the cycle after accept; res_valid the cycle after the last MAC byte.
// Backpressure: cmd_ready only in IDLE; result held until res_ready; key/msg strobes are never gapped.
module aes_sha3_host_seq
  import aes_sha3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_sha3_host_seq_if.master  bus
);

  localparam logic [5:0] KEY_N      = 6'(KEY_BYTES);
  localparam logic [5:0] MSG_N      = 6'(MSG_BYTES);
  localparam logic [5:0] CIPHER_END = 6'(CIPHER_BYTES - 1);
  localparam logic [5:0] MAC_END    = 6'(MAC_BYTES - 1);

  state_t         state, state_nxt;
  logic [5:0]     cnt, cnt_nxt;
  logic [255:0]   key_sr, key_sr_nxt;
  logic [127:0]   msg_sr, msg_sr_nxt;
  logic           mode_r, mode_nxt;
  logic           cmd_ready_r, cmd_ready_nxt;
  logic           res_valid_r, res_valid_nxt;
  logic           start_r, start_nxt;
  logic [7:0]     data_r, data_nxt;
  logic           res_clr, cipher_we, mac_we;
  logic [127:0]   cipher_dat;
  logic [255:0]   mac_dat;

`ifdef AES_SHA3_HOST_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        in_wait, progress, timeout;
  logic        err_r;
`endif

  // next-state, next-output and capture-enable decode
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_sr_nxt    = key_sr;
    msg_sr_nxt    = msg_sr;
    mode_nxt      = mode_r;
    res_valid_nxt = res_valid_r;
    start_nxt     = 1'b0;
    data_nxt      = 8'h00;
    res_clr       = 1'b0;
    cipher_we     = 1'b0;
    mac_we        = 1'b0;
`ifdef AES_SHA3_HOST_TIMEOUT_EN
    in_wait       = 1'b0;
    progress      = 1'b0;
    timeout       = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.cmd_valid && cmd_ready_r) begin
          // first key byte goes out straight from the command bus
          state_nxt  = ST_SEND_KEY;
          key_sr_nxt = {bus.cmd_salt_key[247:0], 8'h00};
          msg_sr_nxt = bus.cmd_msg;
          mode_nxt   = bus.cmd_mode;
          start_nxt  = 1'b1;
          data_nxt   = bus.cmd_salt_key[255:248];
          cnt_nxt    = 6'd1;
          res_clr    = 1'b1;
        end
      end

      ST_SEND_KEY: begin
        if (cnt == KEY_N) begin
          cnt_nxt   = '0;
          state_nxt = ST_WAIT_BUSY;
        end else begin
          start_nxt  = 1'b1;
          data_nxt   = key_sr[255:248];
          key_sr_nxt = {key_sr[247:0], 8'h00};
          cnt_nxt    = cnt + 6'd1;
        end
      end

      ST_WAIT_BUSY: begin
        if (bus.dut_ien) state_nxt = ST_WAIT_MSG;
      end

      ST_WAIT_MSG: begin
        // derivation finished: the first message byte leaves on the same edge
        if (!bus.dut_ien) begin
          state_nxt  = ST_SEND_MSG;
          start_nxt  = 1'b1;
          data_nxt   = msg_sr[127:120];
          msg_sr_nxt = {msg_sr[119:0], 8'h00};
          cnt_nxt    = 6'd1;
        end
      end

      ST_SEND_MSG: begin
        if (cnt == MSG_N) begin
          cnt_nxt   = '0;
          state_nxt = ST_WAIT_OUT;
        end else begin
          start_nxt  = 1'b1;
          data_nxt   = msg_sr[127:120];
          msg_sr_nxt = {msg_sr[119:0], 8'h00};
          cnt_nxt    = cnt + 6'd1;
        end
      end

      ST_WAIT_OUT: begin
        if (bus.dut_ovalid) begin
          cipher_we = 1'b1;
          cnt_nxt   = 6'd1;
          state_nxt = ST_RX_CIPHER;
        end
      end

      ST_RX_CIPHER: begin
        if (bus.dut_ovalid) begin
          cipher_we = 1'b1;
          if (cnt == CIPHER_END) begin
            cnt_nxt   = '0;
            state_nxt = ST_RX_MAC;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end

      ST_RX_MAC: begin
        if (bus.dut_ovalid) begin
          mac_we = 1'b1;
          if (cnt == MAC_END) begin
            cnt_nxt       = '0;
            state_nxt     = ST_DONE;
            res_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end

      ST_DONE: begin
        if (res_valid_r && bus.res_ready) begin
          state_nxt     = ST_IDLE;
          res_valid_nxt = 1'b0;
          mode_nxt      = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

`ifdef AES_SHA3_HOST_TIMEOUT_EN
    // no progress for the whole window: abandon the transaction with an error
    in_wait  = state inside {ST_WAIT_BUSY, ST_WAIT_MSG, ST_WAIT_OUT, ST_RX_CIPHER, ST_RX_MAC};
    progress = (state_nxt != state) || cipher_we || mac_we;
    timeout  = in_wait && !progress && (wd_cnt == WD_LAST);
    if (timeout) begin
      state_nxt     = ST_DONE;
      res_valid_nxt = 1'b1;
      cnt_nxt       = '0;
    end
`endif

    cmd_ready_nxt = (state_nxt == ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      key_sr      <= '0;
      msg_sr      <= '0;
      mode_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      start_r     <= 1'b0;
      data_r      <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_sr      <= key_sr_nxt;
      msg_sr      <= msg_sr_nxt;
      mode_r      <= mode_nxt;
      cmd_ready_r <= cmd_ready_nxt;
      res_valid_r <= res_valid_nxt;
      start_r     <= start_nxt;
      data_r      <= data_nxt;
    end
  end

`ifdef AES_SHA3_HOST_TIMEOUT_EN
  // progress watchdog, cleared outside the waiting states and on any progress
  always_ff @(posedge clk) begin
    if (rst || !in_wait || progress) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  // error flag lives for the duration of the aborted result
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (timeout) begin
      err_r <= 1'b1;
    end else if (state == ST_DONE && res_valid_r && bus.res_ready) begin
      err_r <= 1'b0;
    end
  end

  assign bus.res_err = err_r;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus.res_err    = 1'b0;
`endif

  byte_deser #(.NBYTES(CIPHER_BYTES)) u_cipher (
    .clk (clk),
    .rst (rst),
    .clr (res_clr),
    .we  (cipher_we),
    .idx (cnt[3:0]),
    .din (bus.dut_odata),
    .dat (cipher_dat)
  );

  byte_deser #(.NBYTES(MAC_BYTES)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (res_clr),
    .we  (mac_we),
    .idx (cnt[4:0]),
    .din (bus.dut_odata),
    .dat (mac_dat)
  );

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_cipher = cipher_dat;
  assign bus.res_mac    = mac_dat;
  assign bus.dut_data   = data_r;
  assign bus.dut_start  = start_r;
  assign bus.dut_mode   = mode_r;

endmodule

// File: tb/tb_aes_sha3_host_seq.sv
// Directed bench for aes_sha3_host_seq with byte and result scoreboards.
// Latency: checks first-byte, message-restart and result timing.
// Backpressure: holds res_ready low and offers commands while busy.
module tb_aes_sha3_host_seq;
  import aes_sha3_pkg::*;

`ifdef AES_SHA3_HOST_TIMEOUT_EN
  localparam int HOLD = 60;
`else
  localparam int HOLD = 500;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_sha3_host_seq_if bus();

  aes_sha3_host_seq #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0]   byte_q[$];
  logic [255:0] res_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [255:0] sk, input logic [127:0] m, input logic md);
    bus.cmd_salt_key = sk;
    bus.cmd_msg      = m;
    bus.cmd_mode     = md;
    bus.cmd_valid    = 1'b1;
    for (int i = 0; i < KEY_BYTES; i++) byte_q.push_back(sk[255-8*i -: 8]);
    for (int i = 0; i < MSG_BYTES; i++) byte_q.push_back(m[127-8*i -: 8]);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int n);
    int gaps;
    logic [7:0] e;
    gaps = 0;
    for (int i = 0; i < n; i++) begin
      e = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
      if (bus.dut_start !== 1'b1) gaps++;
      check(tag, 256'(bus.dut_data), 256'(e));
      tick();
    end
    check({tag, "_gaps"}, 256'(gaps), 256'(0));
    check({tag, "_end"}, 256'(bus.dut_start), 256'(0));
  endtask

  // raise busy, hold it, drop it and expect the first message strobe promptly
  task automatic handshake(input string tag, input int hold);
    int strobes;
    int lat;
    bus.dut_ien = 1'b1;
    strobes = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.dut_start) strobes++;
    end
    check({tag, "_quiet"}, 256'(strobes), 256'(0));
    bus.dut_ien = 1'b0;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (bus.dut_start) break;
    end
    check({tag, "_lat"}, 256'(lat >= 1 && lat <= 2), 256'(1));
  endtask

  task automatic send_out(input logic [7:0] cbase, input logic [7:0] mbase, input int nmac);
    for (int i = 0; i < CIPHER_BYTES; i++) begin
      bus.dut_ovalid = 1'b1;
      bus.dut_odata  = cbase + 8'(i);
      tick();
    end
    bus.dut_ovalid = 1'b0;
    bus.dut_odata  = 8'h00;
    tick();
    for (int i = 0; i < nmac; i++) begin
      bus.dut_ovalid = 1'b1;
      bus.dut_odata  = mbase + 8'(i);
      tick();
    end
    bus.dut_ovalid = 1'b0;
  endtask

  function automatic logic [255:0] ramp(input logic [7:0] base, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  initial begin
    logic [255:0] sk, sk2, exp_c, exp_m;
    logic [127:0] m, m2;
    logic stable;
    int cyc;

    bus.cmd_valid = 1'b0; bus.cmd_salt_key = '0; bus.cmd_msg = '0; bus.cmd_mode = 1'b0;
    bus.res_ready = 1'b0; bus.dut_odata = 8'h00; bus.dut_ovalid = 1'b0; bus.dut_ien = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("rst_res_valid", 256'(bus.res_valid), 256'(0));
    check("rst_res_err", 256'(bus.res_err), 256'(0));
    check("rst_dut_start", 256'(bus.dut_start), 256'(0));
    check("rst_dut_data", 256'(bus.dut_data), 256'(0));
    check("rst_dut_mode", 256'(bus.dut_mode), 256'(0));
    check("rst_cipher", 256'(bus.res_cipher), 256'(0));
    check("rst_mac", bus.res_mac, 256'(0));
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", 256'(bus.cmd_ready), 256'(1));

    // transaction 1: ascending key bytes, A0..AF message
    for (int i = 0; i < 32; i++) sk[255-8*i -: 8] = 8'(i);
    for (int i = 0; i < 16; i++) m[127-8*i -: 8] = 8'hA0 + 8'(i);
    send_cmd(sk, m, 1'b1);
    check("t1_mode", 256'(bus.dut_mode), 256'(1));
    check("t1_busy", 256'(bus.cmd_ready), 256'(0));
    check_stream("t1_key", KEY_BYTES);
    // stray core byte and a new command while waiting: both must be ignored
    bus.dut_ovalid = 1'b1; bus.dut_odata = 8'hEE; bus.cmd_valid = 1'b1;
    tick();
    bus.dut_ovalid = 1'b0; bus.cmd_valid = 1'b0;
    handshake("t1_hs", HOLD);
    check_stream("t1_msg", MSG_BYTES);
    exp_c = ramp(8'h10, 16);
    exp_m = ramp(8'h40, 32);
    res_q.push_back(exp_c);
    res_q.push_back(exp_m);
    repeat (3) tick();
    send_out(8'h10, 8'h40, 31);
    check("t1_valid_early", 256'(bus.res_valid), 256'(0));
    bus.dut_ovalid = 1'b1; bus.dut_odata = 8'h5F;
    tick();
    bus.dut_ovalid = 1'b0;
    check("t1_res_valid", 256'(bus.res_valid), 256'(1));
    check("t1_res_err", 256'(bus.res_err), 256'(0));
    check("t1_cipher", 256'(bus.res_cipher), res_q.pop_front());
    check("t1_mac", bus.res_mac, res_q.pop_front());

    // result backpressure with a command offered meanwhile
    bus.cmd_valid = 1'b1; bus.cmd_salt_key = ~sk;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_cipher !== exp_c[127:0] || bus.res_mac !== exp_m ||
          bus.cmd_ready !== 1'b0 || bus.dut_start !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 256'(stable), 256'(1));
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("rel_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("rel_res_valid", 256'(bus.res_valid), 256'(0));
    check("rel_mode", 256'(bus.dut_mode), 256'(0));

    // transaction 2: random payload, mode 0, res_ready already high when valid rises
    for (int i = 0; i < 8; i++) sk2[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) m2[32*i +: 32] = $urandom;
    send_cmd(sk2, m2, 1'b0);
    check("t2_mode", 256'(bus.dut_mode), 256'(0));
    check_stream("t2_key", KEY_BYTES);
    handshake("t2_hs", 5);
    check_stream("t2_msg", MSG_BYTES);
    res_q.push_back(ramp(8'h80, 16));
    res_q.push_back(ramp(8'hC0, 32));
    bus.res_ready = 1'b1;
    send_out(8'h80, 8'hC0, 32);
    check("t2_res_valid", 256'(bus.res_valid), 256'(1));
    check("t2_cipher", 256'(bus.res_cipher), res_q.pop_front());
    check("t2_mac", bus.res_mac, res_q.pop_front());
    tick();
    bus.res_ready = 1'b0;
    check("t2_idle_ready", 256'(bus.cmd_ready), 256'(1));
    check("t2_idle_valid", 256'(bus.res_valid), 256'(0));

    // transaction 3: reset during MAC reception
    send_cmd(sk, m, 1'b1);
    check_stream("t3_key", KEY_BYTES);
    handshake("t3_hs", 3);
    check_stream("t3_msg", MSG_BYTES);
    send_out(8'h10, 8'h40, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_rst_ready", 256'(bus.cmd_ready), 256'(1));
    check("t3_rst_valid", 256'(bus.res_valid), 256'(0));
    check("t3_rst_cipher", 256'(bus.res_cipher), 256'(0));
    check("t3_rst_mac", bus.res_mac, 256'(0));
    check("t3_rst_mode", 256'(bus.dut_mode), 256'(0));

`ifdef AES_SHA3_HOST_TIMEOUT_EN
    // watchdog: core never finishes derivation
    send_cmd(sk, m, 1'b0);
    check_stream("t4_key", KEY_BYTES);
    byte_q.delete();
    bus.dut_ien = 1'b1;
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("wd_valid", 256'(bus.res_valid), 256'(1));
    check("wd_err", 256'(bus.res_err), 256'(1));
    check("wd_window", 256'(cyc >= 100 && cyc <= 103), 256'(1));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.dut_ien = 1'b0;
    check("wd_idle", 256'(bus.cmd_ready), 256'(1));
    check("wd_err_clr", 256'(bus.res_err), 256'(0));
`else
    cyc = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
